multi_dataflow_engine_ctrl: RTL

Engine-side control stage sitting directly downstream of the multi-dataflow control FSM and upstream of the accelerator kernel datapath. It converts the FSM's engine controls (clear/enable/start/count limit/configuration) into a kernel start pulse and gated stream handshakes. It counts output beats delivered to the sink streamer and returns the `cnt`/`ready` engine flags the FSM uses to decide termination. A 2-entry output skid buffer decouples kernel output from sink backpressure.

---
 rtl/multi_dataflow_engine_ctrl_pkg.sv | 30 +++
 rtl/multi_dataflow_skid_buffer.sv | 70 +++++++
 rtl/multi_dataflow_engine_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/multi_dataflow_engine_ctrl_pkg.sv
// Shared types and default widths for the multi-dataflow engine control stage.
// Imported by the engine controller and its output skid buffer.
package multi_dataflow_package;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_CNT_W  = 16;
    localparam int DEFAULT_CFG_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_RUN,
        ST_DONE
    } engine_state_t;

    typedef struct packed {
        logic                     clear;
        logic                     enable;
        logic                     start;
        logic [DEFAULT_CNT_W-1:0] cnt_limit;
        logic [DEFAULT_CFG_W-1:0] configuration;
    } ctrl_engine_ctrl_t;

    typedef struct packed {
        logic [DEFAULT_CNT_W-1:0] cnt;
        logic                     ready;
        logic                     done;
    } flags_engine_ctrl_t;

endpackage

// File: rtl/multi_dataflow_skid_buffer.sv
// Two-entry skid buffer between kernel output and sink streamer.
// Output is taken straight from storage, so out_valid_o is a registered signal.
module multi_dataflow_skid_buffer
    import multi_dataflow_package::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              push;
    logic              pop;

    assign full_o      = (count_q == 2'd2);
    assign empty_o     = (count_q == 2'd0);
    // A pop frees the head slot in the same cycle, so a full buffer still accepts.
    assign in_ready_o  = ~full_o | out_ready_i;
    assign out_valid_o = ~empty_o;
    assign out_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // NOTE: data storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/multi_dataflow_engine_ctrl.sv
// Engine control stage: turns FSM engine controls into a kernel start pulse and
// gated stream handshakes, and counts sink beats to report cnt/ready/done.
module multi_dataflow_engine_ctrl
    import multi_dataflow_package::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter int CFG_W  = DEFAULT_CFG_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              test_mode_i,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  cnt_limit_i,
    input  logic [CFG_W-1:0]  configuration_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] krn_in_data_o,
    output logic              krn_in_valid_o,
    input  logic              krn_in_ready_i,
    input  logic [DATA_W-1:0] krn_out_data_i,
    input  logic              krn_out_valid_i,
    output logic              krn_out_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              krn_start_o,
    output logic [CFG_W-1:0]  krn_config_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              ready_o,
    output logic              done_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    engine_state_t    state_q;
    engine_state_t    state_d;
    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] acc_q;
    logic [CFG_W-1:0] cfg_q;
    logic             active;
    logic             in_run;
    logic             start_job;
    logic             krn_hs;
    logic             sink_hs;
    logic             skid_pop;
    logic             skid_full;
    logic             last_beat;
    logic [1:0]       unused_skid_flags;
    logic             unused_test_mode;

    assign unused_test_mode = test_mode_i;

    // Clear outranks everything and enable low freezes, so both block handshakes.
    assign active = enable_i & ~clear_i;
    assign in_run = (state_q == ST_RUN);

    assign krn_in_data_o   = in_data_i;
    assign krn_in_valid_o  = in_run & active & in_valid_i;
    assign in_ready_o      = in_run & active & krn_in_ready_i;
    assign krn_out_ready_o = in_run & active & ~skid_full & (acc_q < limit_q);
    assign krn_hs          = krn_out_valid_i & krn_out_ready_o;
    assign skid_pop        = in_run & active & out_ready_i;
    assign sink_hs         = out_valid_o & skid_pop;
    assign last_beat       = ((cnt_q + CNT_ONE) == limit_q);

    assign ready_o      = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign done_o       = (state_q == ST_DONE);
    assign cnt_o        = cnt_q;
    assign krn_config_o = cfg_q;

    multi_dataflow_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (clear_i),
        .in_data_i   (krn_out_data_i),
        .in_valid_i  (krn_hs),
        .in_ready_o  (unused_skid_flags[0]),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (skid_pop),
        .full_o      (skid_full),
        .empty_o     (unused_skid_flags[1])
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        start_job   = 1'b0;
        krn_start_o = 1'b0;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else if (enable_i) begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        start_job = 1'b1;
                        state_d   = ST_CONFIG;
                    end
                end
                ST_CONFIG: begin
                    krn_start_o = 1'b1;
                    state_d     = (limit_q == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    if (sink_hs && last_beat) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // acc_q cannot pass limit_q because krn_out_ready_o already requires acc_q < limit_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            limit_q <= '0;
            cfg_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (start_job) begin
            limit_q <= cnt_limit_i;
            cfg_q   <= configuration_i;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            if (krn_hs) begin
                acc_q <= acc_q + CNT_ONE;
            end
            if (sink_hs) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

endmodule
